// File: rtl/ej32_pkg.sv
// Shared opcode, unit and decode-table definitions for the EJ32 decode/sequencer.
// The wide prefix (0xC4) is only decoded when EJ32_WIDE_EN is defined.
package ej32_pkg;

    localparam int UNIT_W = 3;
    localparam int NPH_W  = 3;

    localparam logic [1:0] AU = 2'd0;
    localparam logic [1:0] BR = 2'd1;
    localparam logic [1:0] LS = 2'd2;

    localparam logic [UNIT_W-1:0] M_NONE = 3'b000;
    localparam logic [UNIT_W-1:0] M_AU   = 3'b001;
    localparam logic [UNIT_W-1:0] M_BR   = 3'b010;
    localparam logic [UNIT_W-1:0] M_LS   = 3'b100;

    typedef enum logic [7:0] {
        OP_NOP     = 8'h00,
        OP_ICONST0 = 8'h03,
        OP_BIPUSH  = 8'h10,
        OP_SIPUSH  = 8'h11,
        OP_ILOAD   = 8'h15,
        OP_IALOAD  = 8'h2E,
        OP_ISTORE  = 8'h36,
        OP_IASTORE = 8'h4F,
        OP_IADD    = 8'h60,
        OP_ISUB    = 8'h64,
        OP_IMUL    = 8'h68,
        OP_IDIV    = 8'h6C,
        OP_IREM    = 8'h70,
        OP_IINC    = 8'h84,
        OP_IFEQ    = 8'h99,
        OP_GOTO    = 8'hA7,
        OP_IRETURN = 8'hAC,
        OP_WIDE    = 8'hC4
    } opcode_t;

    typedef enum logic [1:0] {
        CL_STEP,
        CL_WAIT,
        CL_BUSY
    } cls_t;

    typedef struct packed {
        logic              vld;
        logic [UNIT_W-1:0] mask;
        logic [NPH_W-1:0]  nph;
        cls_t              cls;
        logic [1:0]        bunit;
    } entry_t;

    function automatic entry_t mkEntry(input logic [UNIT_W-1:0] mask,
                                       input logic [NPH_W-1:0]  nph,
                                       input cls_t              cls,
                                       input logic [1:0]        bunit);
        entry_t e;
        e.vld   = 1'b1;
        e.mask  = mask;
        e.nph   = nph;
        e.cls   = cls;
        e.bunit = bunit;
        return e;
    endfunction

endpackage

// File: rtl/ej32_dc_rom.sv
// Combinational opcode-to-entry lookup; unknown opcodes come back invalid as a one-phase STEP.
// Decodes the wide prefix only when EJ32_WIDE_EN is defined.
module ej32_dc_rom
    import ej32_pkg::*;
(
    input  logic [7:0] i_code,
    output entry_t     o_entry
);

    always_comb begin
        o_entry     = mkEntry(M_NONE, 3'd1, CL_STEP, AU);
        o_entry.vld = 1'b0;
        case (i_code)
            OP_NOP:     o_entry = mkEntry(M_NONE, 3'd1, CL_STEP, AU);
            OP_ICONST0: o_entry = mkEntry(M_AU,   3'd1, CL_STEP, AU);
            OP_BIPUSH:  o_entry = mkEntry(M_AU,   3'd2, CL_STEP, AU);
            OP_SIPUSH:  o_entry = mkEntry(M_AU,   3'd3, CL_STEP, AU);
            OP_ILOAD:   o_entry = mkEntry(M_LS,   3'd2, CL_STEP, LS);
            OP_ISTORE:  o_entry = mkEntry(M_LS,   3'd2, CL_STEP, LS);
            OP_IALOAD:  o_entry = mkEntry(M_LS,   3'd3, CL_WAIT, LS);
            OP_IASTORE: o_entry = mkEntry(M_LS,   3'd3, CL_WAIT, LS);
            OP_IADD:    o_entry = mkEntry(M_AU,   3'd1, CL_STEP, AU);
            OP_ISUB:    o_entry = mkEntry(M_AU,   3'd1, CL_STEP, AU);
            OP_IMUL:    o_entry = mkEntry(M_AU,   3'd2, CL_BUSY, AU);
            OP_IDIV:    o_entry = mkEntry(M_AU,   3'd2, CL_BUSY, AU);
            OP_IREM:    o_entry = mkEntry(M_AU,   3'd2, CL_BUSY, AU);
            OP_IINC:    o_entry = mkEntry(M_AU,   3'd3, CL_STEP, AU);
            OP_IFEQ:    o_entry = mkEntry(M_BR,   3'd3, CL_STEP, BR);
            OP_GOTO:    o_entry = mkEntry(M_BR,   3'd3, CL_STEP, BR);
            OP_IRETURN: o_entry = mkEntry(M_BR | M_LS, 3'd2, CL_BUSY, LS);
`ifdef EJ32_WIDE_EN
            OP_WIDE:    o_entry = mkEntry(M_NONE, 3'd1, CL_STEP, AU);
`endif
            default: ;
        endcase
    end

endmodule

// File: rtl/ej32_dcx.sv
// EJ32 phase sequencer: steps each opcode through its phases and produces unit enables and the next fetch address.
// Define EJ32_WIDE_EN to honour the wide prefix (doubles the next STEP opcode's operand phases).
module ej32_dcx
    import ej32_pkg::*;
#(
    parameter int unsigned COLD   = 'h0,
    parameter int          ASZ    = 16,
    parameter int          PH_W   = 3,
    parameter int          N_UNIT = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        code,
    input  logic [ASZ-1:0]    p,
    input  logic              fetch_vld,
    input  logic [N_UNIT-1:0] bsy,
    input  logic              flush,
    input  logic [ASZ-1:0]    tgt,
    output logic [N_UNIT-1:0] un_en,
    output logic [ASZ-1:0]    dc_p_o,
    output logic              dc_code,
    output logic [PH_W-1:0]   dc_phase,
    output logic              dc_last,
    output logic              dc_err
);

    entry_t          w_entry;
    logic [PH_W-1:0] w_nphBase;
    logic [PH_W-1:0] w_nph;
    logic            w_last;
    logic            w_hold;
    logic            w_advance;
    logic [ASZ-1:0]  w_pInc;

    logic [PH_W-1:0] r_phase;
    logic [ASZ-1:0]  r_pO;
    logic            r_code;
    logic            r_err;

    ej32_dc_rom u_rom (
        .i_code  (code),
        .o_entry (w_entry)
    );

    assign w_nphBase = PH_W'(w_entry.nph);

`ifdef EJ32_WIDE_EN
    logic r_wide;
    logic w_isWide;

    assign w_isWide = (code == OP_WIDE);
    // After a wide prefix each operand byte phase of a STEP opcode is doubled: 1 + 2*(NPH-1).
    assign w_nph = (r_wide && (w_entry.cls == CL_STEP)) ? ((w_nphBase << 1) - PH_W'(1)) : w_nphBase;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wide <= 1'b0;
        end else if (flush) begin
            r_wide <= 1'b0;
        end else if (w_advance && w_last) begin
            r_wide <= w_isWide;
        end
    end
`else
    assign w_nph = w_nphBase;
`endif

    // Treat any phase at or past the last one as final so the counter can never run beyond NPH-1.
    assign w_last    = (r_phase >= (w_nph - PH_W'(1)));
    assign w_hold    = (w_entry.cls == CL_BUSY) && (r_phase != '0) && bsy[w_entry.bunit];
    assign w_advance = fetch_vld && !w_hold;
    assign w_pInc    = p + ASZ'(1);

    assign un_en    = (fetch_vld && !flush) ? N_UNIT'(w_entry.mask) : '0;
    assign dc_last  = w_last;
    assign dc_phase = r_phase;
    assign dc_p_o   = r_pO;
    assign dc_code  = r_code;
    assign dc_err   = r_err;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_phase <= '0;
            r_code  <= 1'b1;
            r_pO    <= ASZ'(COLD);
            r_err   <= 1'b0;
        end else if (flush) begin
            r_phase <= '0;
            r_code  <= 1'b1;
            r_pO    <= tgt;
            r_err   <= 1'b0;
        end else if (!w_advance) begin
            r_err   <= 1'b0;
        end else if (w_last) begin
            r_phase <= '0;
            r_code  <= 1'b1;
            r_pO    <= w_pInc;
            r_err   <= !w_entry.vld;
        end else begin
            r_phase <= r_phase + PH_W'(1);
            r_code  <= 1'b0;
            r_pO    <= (w_entry.cls == CL_STEP) ? w_pInc : p;
            r_err   <= 1'b0;
        end
    end

endmodule

// File: doc/ej32_dcx.md
EJ32_DCX -- requirements
Module: ej32_dcx

Interface
REQ-001 SHALL have parameters: COLD, default 'h0, cold-start address; ASZ, default 16, address width; PH_W, default 3, phase width; N_UNIT, default 3, execution-unit count (AU, BR, LS).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; asynchronous and active-low.
REQ-004 code  input  8  current opcode.
REQ-005 p  input  ASZ  current instruction address.
REQ-006 fetch_vld  input  1  opcode/operand byte valid; low means stall.
REQ-007 bsy  input  N_UNIT  per-unit busy.
REQ-008 flush  input  1  redirect request.
REQ-009 tgt  input  ASZ  redirect address.
REQ-010 un_en  output  N_UNIT  unit enables (bit0 AU, bit1 BR, bit2 LS).
REQ-011 dc_p_o  output  ASZ  next fetch address (registered).
REQ-012 dc_code  output  1  load-new-opcode strobe (registered).
REQ-013 dc_phase  output  PH_W  current phase (registered).
REQ-014 dc_last  output  1  current phase is final phase of opcode (combinational).
REQ-015 dc_err  output  1  illegal-opcode pulse (registered, one cycle).

Function
REQ-016 Each opcode SHALL map to a table entry: unit mask, phase count NPH (1..2^PH_W-1), class STEP (operand bytes, p advances every phase), WAIT (p held in non-final phases), or BUSY (WAIT plus hold while bsy of a named unit).
REQ-017 Non-final phase: phase<=phase+1, dc_code<=0, dc_p_o<=p+1 for STEP, held for WAIT/BUSY.
REQ-018 Final phase (phase==NPH-1): phase<=0, dc_code<=1, dc_p_o<=p+1; dc_last=1.
REQ-019 BUSY class: from phase 1 on, while bsy[unit]=1, phase, dc_code, dc_p_o SHALL hold; the phase advances on the first cycle with bsy[unit]=0.
REQ-020 un_en SHALL equal the entry's unit mask in every phase; while fetch_vld=0 un_en SHALL be 0 and all registers hold.
REQ-021 flush=1 SHALL, on the next edge, set phase<=0, dc_code<=1, dc_p_o<=tgt, overriding stall, busy and phase progression; un_en SHALL be 0 in that cycle.
REQ-022 Undefined opcode: un_en=0, treated as a one-phase STEP, dc_err<=1 for one cycle.
REQ-023 Phase counter SHALL never exceed NPH-1; the dc_p_o increment SHALL wrap modulo 2^ASZ.
REQ-024 Priority: reset > flush > fetch_vld stall > busy hold > normal progression.

Reset
REQ-025 While rst=0: phase=0, dc_code=1, dc_p_o=COLD, dc_err=0, wide flag=0, taking effect immediately, including mid-instruction.
REQ-026 First edge after rst rises SHALL decode code at p=COLD from phase 0.

Configuration
REQ-027 Macro EJ32_WIDE_EN: when defined, opcode 0xC4 (wide) SHALL be a one-phase STEP that sets a wide flag; the next opcode's STEP operand phase count is doubled (iload 2->3 phases, iinc 3->5); flag clears on that opcode's final phase or on flush.
REQ-028 Without EJ32_WIDE_EN, 0xC4 SHALL be an undefined opcode per REQ-022 and no wide flag SHALL exist.

Structure
REQ-029 ej32_pkg SHALL hold opcode_t, unit-index constants (AU=0, BR=1, LS=2), the class enum and the table-entry struct.
REQ-030 Opcode-to-entry lookup SHALL be a combinational sub-module ej32_dc_rom; ej32_dcx holds phase, flag and output registers.

Verification
REQ-031 COLD=0, rst released, code=iadd, p=0 -> un_en=001, dc_last=1; after 1 edge dc_p_o=1, dc_code=1, phase=0.
REQ-032 sipush at p=0x10 -> phases 0,1,2 over 3 edges; dc_p_o 0x11, 0x12, 0x13; dc_code 0,0,1.
REQ-033 idiv at p=0x20, bsy[0]=1 for 4 cycles after phase 1 -> phase stays 1, dc_p_o stays 0x20 for 4 cycles; bsy[0]=0 -> phase 0, dc_p_o=0x21, dc_code=1.
REQ-034 iaload in phase 2, flush=1, tgt=0x40, fetch_vld=0 -> next edge phase=0, dc_p_o=0x40, dc_code=1, un_en=0.
REQ-035 sipush phase 1, fetch_vld=0 for 2 cycles -> phase, dc_p_o frozen, un_en=0; resume completes normally; rst=0 mid-sipush -> immediately phase=0, dc_p_o=COLD.
REQ-036 With EJ32_WIDE_EN: 0xC4 then iload at p=0x30 -> iload takes 3 phases, dc_p_o reaches 0x34; without macro: 0xC4 -> dc_err=1 one cycle, un_en=0, dc_p_o=0x31.
